collect_capture_buffer: RTL and testbench

//  Parametrised multi-channel capture buffer for the Collect path. It records CH sample lanes

---
 rtl/collect_capture_buffer.sv | 158 +++++++++++++++
 tb/tb_collect_capture_buffer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/collect_capture_buffer.sv
// Multi-channel capture buffer: records CH lanes into a circular RAM while collect is high,
// then drains oldest-first one lane per beat. Optional macro: COLLECT_TIMESTAMP_EN.
module collect_capture_buffer #(
    parameter int CH    = 4,
    parameter int DW    = 16,
    parameter int DEPTH = 256,
    parameter int TS_W  = 16,
    localparam int CW   = (CH > 1) ? $clog2(CH) : 1,
    localparam int AW   = $clog2(DEPTH),
`ifdef COLLECT_TIMESTAMP_EN
    localparam int OW   = DW + TS_W
`else
    localparam int OW   = DW
`endif
) (
    input  logic             clk350,
    input  logic             rstn,
    input  logic             collect,
    input  logic             in_valid,
    input  logic [CH*DW-1:0] in_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [OW-1:0]    m_data,
    output logic [CW-1:0]    m_chan,
    output logic             m_last,
    output logic             busy,
    output logic             overflow,
    output logic [AW:0]      sample_count,
    output logic [1:0]       state_dbg
);
    // Handshake: a beat moves on m_valid && m_ready; while m_valid && !m_ready the beat
    // (m_data/m_chan/m_last) is frozen and m_valid stays high until it is taken.

    if (CH < 1 || DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 || TS_W < 1) begin : g_param_check
        $error("collect_capture_buffer: illegal parameter set");
    end

    typedef enum logic [1:0] {IDLE = 2'd0, COLLECT = 2'd1, DRAIN = 2'd2} state_t;
    state_t state, state_nx;

    localparam int SW = CH * DW;
`ifdef COLLECT_TIMESTAMP_EN
    localparam int RW = SW + TS_W;
    logic [TS_W-1:0] ts;
`else
    localparam int RW = SW;
`endif

    logic [RW-1:0] mem [DEPTH];
    logic [RW-1:0] ram_q, out_word, wr_word;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   rd_left;
    logic          q_valid, q_last, out_last;
    logic          fire, chan_end, load_out, rd_en, wr_en;
    logic [DW-1:0] lane;

    assign fire     = m_valid && m_ready;
    assign chan_end = (m_chan == CW'(CH - 1));
    // The fetched word moves to the output stage when it is empty or emitting its last lane.
    assign load_out = q_valid && (!m_valid || (fire && chan_end));
    assign rd_en    = (state == DRAIN) && (rd_left != '0) && (!q_valid || load_out);
    assign wr_en    = (state == COLLECT) && collect && in_valid;
    assign m_last   = m_valid && out_last && chan_end;
    assign busy     = (state != IDLE);
    assign state_dbg = state;

`ifdef COLLECT_TIMESTAMP_EN
    assign wr_word = {ts, in_data};

    always_ff @(posedge clk350 or negedge rstn) begin
        if (!rstn) ts <= '0;
        else       ts <= ts + TS_W'(1);
    end
`else
    assign wr_word = in_data;
`endif

    always_ff @(posedge clk350 or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (collect) state_nx = COLLECT;
            COLLECT: if (!collect) state_nx = (sample_count == '0) ? IDLE : DRAIN;
            DRAIN:   if (fire && m_last) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk350) begin
        if (wr_en) mem[wr_ptr] <= wr_word;
        if (rd_en) ram_q <= mem[rd_ptr];
    end

    always_ff @(posedge clk350 or negedge rstn) begin
        if (!rstn) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            rd_left      <= '0;
            sample_count <= '0;
            overflow     <= 1'b0;
            q_valid      <= 1'b0;
            q_last       <= 1'b0;
            out_word     <= '0;
            out_last     <= 1'b0;
            m_chan       <= '0;
            m_valid      <= 1'b0;
        end else begin
            if (state == IDLE && collect) begin
                wr_ptr       <= '0;
                sample_count <= '0;
                overflow     <= 1'b0;
            end
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
                if (sample_count == (AW + 1)'(DEPTH)) overflow <= 1'b1;
                else                                   sample_count <= sample_count + (AW + 1)'(1);
            end
            // Oldest entry sits sample_count slots behind the write pointer.
            if (state == COLLECT && !collect) begin
                rd_ptr  <= wr_ptr - sample_count[AW-1:0];
                rd_left <= sample_count;
            end
            if (rd_en) begin
                rd_ptr  <= rd_ptr + AW'(1);
                rd_left <= rd_left - (AW + 1)'(1);
                q_last  <= (rd_left == (AW + 1)'(1));
            end
            if (rd_en)         q_valid <= 1'b1;
            else if (load_out) q_valid <= 1'b0;
            if (load_out) begin
                out_word <= ram_q;
                out_last <= q_last;
                m_chan   <= '0;
                m_valid  <= 1'b1;
            end else if (fire) begin
                if (chan_end) m_valid <= 1'b0;
                else          m_chan  <= m_chan + CW'(1);
            end
        end
    end

    always_comb begin
        lane = '0;
        for (int k = 0; k < CH; k++) begin
            if (m_chan == CW'(k)) lane = out_word[k*DW +: DW];
        end
`ifdef COLLECT_TIMESTAMP_EN
        m_data = {out_word[SW +: TS_W], lane};
`else
        m_data = lane;
`endif
    end

endmodule

// File: tb/tb_collect_capture_buffer.sv
// Self-checking bench for collect_capture_buffer (default build and COLLECT_TIMESTAMP_EN).
module tb_collect_capture_buffer;
    localparam int CH    = 4;
    localparam int DW    = 16;
    localparam int DEPTH = 256;
    localparam int TS_W  = 16;
    localparam int CW    = (CH > 1) ? $clog2(CH) : 1;
    localparam int AW    = $clog2(DEPTH);
`ifdef COLLECT_TIMESTAMP_EN
    localparam int OW    = DW + TS_W;
`else
    localparam int OW    = DW;
`endif
    localparam int W     = DW + CW + 1;

    logic             clk350, rstn, collect, in_valid, m_ready;
    logic [CH*DW-1:0] in_data;
    logic             m_valid, m_last, busy, overflow;
    logic [OW-1:0]    m_data;
    logic [CW-1:0]    m_chan;
    logic [AW:0]      sample_count;
    logic [1:0]       state_dbg;

    logic [W-1:0]     exp_q[$];
    logic [CH*DW-1:0] model_q[$];
    int               n_checks = 0;
    int               n_fail   = 0;
    int               last_gap = 1;

    collect_capture_buffer #(.CH(CH), .DW(DW), .DEPTH(DEPTH), .TS_W(TS_W)) dut (
        .clk350(clk350), .rstn(rstn), .collect(collect), .in_valid(in_valid),
        .in_data(in_data), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_chan(m_chan), .m_last(m_last), .busy(busy), .overflow(overflow),
        .sample_count(sample_count), .state_dbg(state_dbg)
    );

    // clock / reset
    initial begin
        clk350 = 1'b0;
        forever #5 clk350 = ~clk350;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // driver: opens a window, writes n entries (gap idle cycles after each), closes it
    task automatic capture(input int n, input int gap, input bit valid_on_fall, input int base);
        logic [CH*DW-1:0] w;
        model_q.delete();
        @(negedge clk350);
        collect  = 1'b1;
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk350);
            for (int k = 0; k < CH; k++) w[k*DW +: DW] = DW'(base + CH * i + k);
            in_valid = 1'b1;
            in_data  = w;
            model_q.push_back(w);
            if (model_q.size() > DEPTH) void'(model_q.pop_front());
            for (int g = 0; g < gap; g++) begin
                @(negedge clk350);
                in_valid = 1'b0;
            end
        end
        @(negedge clk350);
        collect  = 1'b0;
        in_valid = valid_on_fall;
        in_data  = {CH{DW'($urandom_range(0, 65535))}};
        last_gap = gap + 1;
        for (int i = 0; i < model_q.size(); i++)
            for (int k = 0; k < CH; k++)
                exp_q.push_back({(i == model_q.size() - 1) && (k == CH - 1), CW'(k),
                                 model_q[i][k*DW +: DW]});
    endtask

    // consumer: must be called right after capture; checks every beat against exp_q
    task automatic drain(input bit rnd, input bit hold_collect, input int budget);
        int cyc, first_valid, beats;
        bit done, stalled;
        logic [63:0] held;
        logic [W-1:0] e;
`ifdef COLLECT_TIMESTAMP_EN
        logic [TS_W-1:0] ts, entry_ts;
        bit have_prev;
        have_prev = 1'b0;
        entry_ts  = '0;
`endif
        cyc = 0; first_valid = -1; beats = 0; done = 1'b0; stalled = 1'b0; held = '0;
        while (!done && cyc < budget) begin
            @(negedge clk350);
            in_valid = 1'b0;
            collect  = hold_collect;
            if (stalled) chk("stall_hold", {m_valid, m_last, m_chan, m_data}, held);
            m_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (m_valid && first_valid < 0) first_valid = cyc;
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_beat", 1, 0);
                    done = 1'b1;
                end else begin
                    e = exp_q.pop_front();
                    beats++;
                    chk("beat", {m_last, m_chan, m_data[DW-1:0]}, e);
`ifdef COLLECT_TIMESTAMP_EN
                    ts = m_data[OW-1:DW];
                    if (m_chan == '0) begin
                        if (have_prev) chk("ts_step", TS_W'(ts - entry_ts), TS_W'(last_gap));
                        have_prev = 1'b1;
                        entry_ts  = ts;
                    end else begin
                        chk("ts_same", ts, entry_ts);
                    end
`endif
                    done = (exp_q.size() == 0);
                end
            end
            stalled = m_valid && !m_ready;
            held    = {m_valid, m_last, m_chan, m_data};
            cyc++;
        end
        chk("drain_complete", done, 1);
        chk("first_latency", first_valid, 2);
        if (!rnd) chk("no_bubbles", cyc - first_valid, beats);
        exp_q.delete();
    endtask

    task automatic post_idle();
        @(negedge clk350);
        chk("post_mvalid", m_valid, 0);
        chk("post_busy", busy, 0);
    endtask

    initial begin
        int waited;
        bit any_valid;
        rstn = 1'b0; collect = 1'b0; in_valid = 1'b0; in_data = '0; m_ready = 1'b0;
        repeat (3) @(negedge clk350);
        chk("rst_mvalid", m_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_count", sample_count, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_mlast", m_last, 0);
        rstn = 1'b1;

        // basic: 10 entries, lane k of entry n = 4n+k
        capture(10, 0, 1'b0, 0);
        drain(1'b0, 1'b0, 100);
        post_idle();
        chk("basic_count", sample_count, 10);
        chk("basic_overflow", overflow, 0);

        // wrap: 300 entries into 256 slots
        capture(300, 0, 1'b0, 0);
        drain(1'b0, 1'b0, 1200);
        post_idle();
        chk("wrap_count", sample_count, DEPTH);
        chk("wrap_overflow", overflow, 1);

        // backpressure with random ready
        capture(20, 0, 1'b0, $urandom_range(0, 1000));
        drain(1'b1, 1'b0, 500);
        post_idle();
        chk("bp_overflow", overflow, 0);

        // one-cycle collect pulse, no data
        @(negedge clk350); collect = 1'b1;
        @(negedge clk350); collect = 1'b0;
        any_valid = 1'b0;
        repeat (6) begin
            @(negedge clk350);
            any_valid |= m_valid;
        end
        chk("pulse_no_valid", any_valid, 0);
        chk("pulse_busy", busy, 0);
        chk("pulse_count", sample_count, 0);

        // in_valid on the collect-falling cycle is dropped
        capture(5, 0, 1'b1, 500);
        drain(1'b0, 1'b0, 100);
        post_idle();
        chk("fall_count", sample_count, 5);

        // collect held high through drain re-enters COLLECT right after IDLE
        capture(3, 0, 1'b0, 900);
        drain(1'b0, 1'b1, 100);
        post_idle();
        @(negedge clk350);
        chk("rearm_busy", busy, 1);
        chk("rearm_count", sample_count, 0);
        collect = 1'b0;
        repeat (2) @(negedge clk350);

`ifdef COLLECT_TIMESTAMP_EN
        // gapped input: valid every third cycle
        capture(6, 2, 1'b0, 1500);
        drain(1'b0, 1'b0, 100);
        post_idle();
`endif

        // reset in the middle of a drain
        capture(8, 0, 1'b0, 2000);
        exp_q.delete();
        waited = 0;
        do begin
            @(negedge clk350);
            m_ready = 1'b1;
            waited++;
        end while (!m_valid && waited < 20);
        chk("midrst_valid_seen", m_valid, 1);
        repeat (2) @(negedge clk350);
        rstn = 1'b0;
        #1;
        chk("midrst_mvalid", m_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_beat", {m_last, m_chan, m_data}, 0);
        chk("midrst_count", sample_count, 0);
        @(negedge clk350);
        rstn = 1'b1;
        any_valid = 1'b0;
        repeat (5) begin
            @(negedge clk350);
            any_valid |= m_valid | busy;
        end
        chk("midrst_quiet", any_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
